// File: rtl/stuffed_frame_tx.sv
// stuffed_frame_tx: framing transmitter emitting "11" sync, a "0" guard bit, then an MSB-first payload with a "0" stuffed after every payload "1"
module stuffed_frame_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bit_en,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              tx_bit,
  output logic              busy,
  output logic              frame_done
);
  localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [2:0] {IDLE, PEND, SYNC1, SYNC2, GUARD, DATA, STUFF} state_t;
  state_t            state;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_nx;
  logic [CW-1:0]     cnt;
  logic              last;
  assign sh_nx   = sh << 1;
  assign last    = cnt == CW'(DATA_W - 1);
  assign s_ready = (state == IDLE) && reset_n;
  assign busy    = state != IDLE;
  // Frame sequencer: IDLE accepts words on any edge, every other move waits for bit_en; tx_bit is the bit of the state being entered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      tx_bit     <= 1'b0;
      frame_done <= 1'b0;
      sh         <= '0;
      cnt        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE) begin
        if (s_valid) begin
          sh     <= s_data;
          cnt    <= '0;
          state  <= bit_en ? SYNC1 : PEND;
          tx_bit <= bit_en;
        end
      end else if (bit_en) begin
        case (state)
          PEND: begin
            state  <= SYNC1;
            tx_bit <= 1'b1;
          end
          SYNC1: begin
            state  <= SYNC2;
            tx_bit <= 1'b1;
          end
          SYNC2: begin
            state  <= GUARD;
            tx_bit <= 1'b0;
          end
          GUARD: begin
            state  <= DATA;
            tx_bit <= sh[DATA_W-1];
          end
          DATA, STUFF: begin
            if (state == DATA && sh[DATA_W-1]) begin
              state  <= STUFF;
              tx_bit <= 1'b0;
            end else if (last) begin
              state      <= IDLE;
              tx_bit     <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              state  <= DATA;
              sh     <= sh_nx;
              cnt    <= cnt + 1'b1;
              tx_bit <= sh_nx[DATA_W-1];
            end
          end
          default: begin
            state  <= IDLE;
            tx_bit <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
